// File: rtl/seg_scan_controller.sv
// seg_scan_controller
//
// Scans an 8-digit multiplexed seven-segment display from a 32-bit value.
// One hex digit is lit at a time for DIV clock cycles; the full frame is
// 8*DIV cycles. Incoming values pass through a one-entry pending buffer and
// are only copied into the display register at a frame boundary, so a frame
// never shows a mix of old and new digits.
//
// Ports
//   clk          system clock, all state on the rising edge
//   clear        synchronous active-high reset
//   data_in      value to show; nibble i drives digit i (digit 0 = LSB)
//   data_valid   producer offers data_in this cycle
//   data_ready   pending buffer is empty; transfer on data_valid & data_ready
//   blank_lz     enable leading-zero blanking (digit 0 is never blanked)
//   frame_done   one-cycle pulse after each frame boundary
//   eight_decode segments {g,f,e,d,c,b,a}, active-low
//   mie          digit enables, active-low one-hot
module seg_scan_controller #(
  parameter int unsigned DIV = 100000,
  parameter int unsigned CW  = 17
) (
  input  logic        clk,
  input  logic        clear,
  input  logic [31:0] data_in,
  input  logic        data_valid,
  output logic        data_ready,
  input  logic        blank_lz,
  output logic        frame_done,
  output logic [6:0]  eight_decode,
  output logic [7:0]  mie
);

  localparam logic [CW-1:0] CntMax = CW'(DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [31:0]   disp_q, disp_d;
  logic [31:0]   pend_q, pend_d;
  logic          full_q, full_d;
  logic          frame_done_q, frame_done_d;
  logic [7:0]    mie_q, mie_d;
  logic [6:0]    seg_q, seg_d;

  logic       tick;
  logic       boundary;
  logic       accept;
  logic [3:0] nibble;
  logic [7:0] upper_zero;
  logic       blank;
  logic [6:0] hex_pat;

  assign tick     = (cnt_q == CntMax);
  assign boundary = tick && (idx_q == 3'd7);
  // Only an empty buffer accepts, so a load at the boundary and a capture
  // can never happen in the same cycle.
  assign accept   = data_valid && !full_q;

  // Refresh counter and digit index.
  always_comb begin
    cnt_d = cnt_q + CW'(1);
    idx_d = idx_q;
    if (tick) begin
      cnt_d = '0;
      idx_d = idx_q + 3'd1;
    end
  end

  // Pending buffer and display register.
  always_comb begin
    pend_d = pend_q;
    full_d = full_q;
    disp_d = disp_q;
    if (boundary && full_q) begin
      disp_d = pend_q;
      full_d = 1'b0;
    end
    if (accept) begin
      pend_d = data_in;
      full_d = 1'b1;
    end
  end

  // upper_zero[i] is set when nibbles i..7 of the display are all zero.
  always_comb begin
    upper_zero = '0;
    for (int i = 0; i < 8; i++) begin
      upper_zero[i] = ((disp_q >> (4 * i)) == 32'd0);
    end
  end

  assign nibble = disp_q[4*idx_q +: 4];
  assign blank  = blank_lz && (idx_q != 3'd0) && upper_zero[idx_q];

  always_comb begin
    hex_pat = 7'h7F;
    case (nibble)
      4'h0: hex_pat = 7'h40;
      4'h1: hex_pat = 7'h79;
      4'h2: hex_pat = 7'h24;
      4'h3: hex_pat = 7'h30;
      4'h4: hex_pat = 7'h19;
      4'h5: hex_pat = 7'h12;
      4'h6: hex_pat = 7'h02;
      4'h7: hex_pat = 7'h78;
      4'h8: hex_pat = 7'h00;
      4'h9: hex_pat = 7'h10;
      4'hA: hex_pat = 7'h08;
      4'hB: hex_pat = 7'h03;
      4'hC: hex_pat = 7'h46;
      4'hD: hex_pat = 7'h21;
      4'hE: hex_pat = 7'h06;
      4'hF: hex_pat = 7'h0E;
      default: hex_pat = 7'h7F;
    endcase
  end

  // Registered outputs lag the digit index / display state by one cycle.
  always_comb begin
    mie_d        = ~(8'b1 << idx_q);
    seg_d        = blank ? 7'h7F : hex_pat;
    frame_done_d = boundary;
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      cnt_q        <= '0;
      idx_q        <= 3'd0;
      disp_q       <= 32'd0;
      pend_q       <= 32'd0;
      full_q       <= 1'b0;
      frame_done_q <= 1'b0;
      mie_q        <= 8'hFF;
      seg_q        <= 7'h7F;
    end else begin
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      disp_q       <= disp_d;
      pend_q       <= pend_d;
      full_q       <= full_d;
      frame_done_q <= frame_done_d;
      mie_q        <= mie_d;
      seg_q        <= seg_d;
    end
  end

  assign data_ready   = !full_q;
  assign frame_done   = frame_done_q;
  assign mie          = mie_q;
  assign eight_decode = seg_q;

endmodule

// File: doc/seg_scan_controller.md
Name: seg_scan_controller

Overview:
- Drives the board's 8-digit multiplexed seven-segment display from a 32-bit value the CPU top level supplies, such as PC, ALU result or register readout.
- Time-multiplexes one hex digit at a time onto the shared segment bus (eight_decode) and its digit enable (mie).
- Double-buffers incoming values so the display only changes on frame boundaries, which prevents tearing.
- Sits between the CPU core and the board pins.

Parameters:
- DIV, 100000: clock cycles each digit is lit. Minimum legal value is 2; the simulation bench uses 4.
- CW, 17: width of the refresh counter. Must satisfy 2^CW >= DIV.

Ports:
- clk, input, 1: system clock; all state updates on the rising edge.
- clear, input, 1: synchronous active-high reset.
- data_in, input, 32: value to display. Nibble i goes to digit i, so digit 0 is the least significant.
- data_valid, input, 1: producer offers data_in this cycle.
- data_ready, output, 1: the pending buffer is empty. A transfer happens in any cycle where data_valid and data_ready are both high.
- blank_lz, input, 1: enables leading-zero blanking.
- frame_done, output, 1: one-cycle pulse at each frame boundary.
- eight_decode, output, 7: segments {g,f,e,d,c,b,a}, active-low.
- mie, output, 8: digit enables, active-low one-hot; bit i enables digit i.

Behaviour:
- Reset (clear=1 at a clk edge):
  - refresh counter = 0, digit index = 0.
  - display register = 0; pending buffer empty.
  - data_ready = 1, frame_done = 0.
  - mie = 8'hFF (all digits off), eight_decode = 7'h7F (all segments off).
  - Reset takes priority over all other inputs. A reset in mid-frame or with the buffer full discards the pending value.
- Refresh counter:
  - Counts 0..DIV-1 and wraps to 0.
  - tick = (counter == DIV-1).
  - On tick, digit index increments modulo 8 (7 -> 0).
- Frame boundary: the tick cycle in which digit index == 7. In that cycle:
  - frame_done = 1, registered, visible the following cycle for exactly one cycle.
  - If the pending buffer is full, the display register loads the pending value and the buffer empties. data_ready returns to 1 the next cycle.
  - If the pending buffer is empty, the display register holds its value.
- Handshake:
  - On data_valid & data_ready, data_in is captured into the pending buffer and data_ready goes to 0 the next cycle.
  - data_valid while data_ready = 0 is ignored and has no side effect.
  - A capture in the boundary cycle itself, with the buffer empty beforehand, is not shown until the next boundary.
  - The producer may hold data_valid high continuously; a new value is then accepted at most once per frame.
- Outputs are registered, one cycle after the digit index / display register state:
  - mie = ~(8'b1 << digit_index).
  - eight_decode = hex pattern of display[4*idx+3 : 4*idx].
  - First post-reset cycle: mie = 8'hFE, eight_decode = pattern of 0.
- Hex patterns (active-low):
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78
  - 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E
- Leading-zero blanking: when blank_lz = 1, digit i with i > 0 and nibbles i..7 all zero outputs eight_decode = 7F. mie still cycles normally. Digit 0 is never blanked.
- Full-frame period = 8*DIV cycles.
- data_in width is fixed at 32 bits; there is no arithmetic beyond the counters.

Test Plan:
- Reset, DIV=4:
  - Hold clear for 2 cycles: mie = FF, eight_decode = 7F, data_ready = 1, frame_done = 0.
  - After release: mie = FE for 4 cycles, then FD, FB, ... 7F, then back to FE. This is a 32-cycle frame.
  - frame_done pulses once per 32 cycles.
- Load 32'h89ABCDEF with a single-cycle data_valid early in frame 1:
  - data_ready drops the next cycle.
  - Display stays all 40 until the boundary; data_ready is high again the cycle after the boundary.
  - Next frame: digit 0 = 0E, digit 1 = 06, digit 2 = 21, digit 3 = 46, digit 4 = 03, digit 5 = 08, digit 6 = 10, digit 7 = 00.
- Back-to-back offers:
  - Hold data_valid high with 32'h1 and then 32'h2 within the same frame: only 32'h1 is accepted.
  - 32'h2 is accepted in the cycle after data_ready re-asserts and is displayed one frame later.
- Leading-zero blanking:
  - Load 32'h00000305 with blank_lz = 1: digits 0..2 show 12, 40, 30; digits 3..7 show 7F.
  - With blank_lz = 0, digits 3..7 show 40.
- Boundary coincidence:
  - Assert data_valid exactly on the boundary tick with the buffer empty: the value is captured but the display is unchanged for the following frame and updates one frame later.
- Reset mid-operation:
  - Assert clear while the buffer is full and digit index = 5: all state returns to its reset values and the pending value is never displayed.
